// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: op encoding,
// sequencer states and the alignment rule.
package data_mem_lsu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam logic [31:0] DATA_SEG_BASE = 32'h1001_0000;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Words need both low address bits clear, halves only bit 0; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (op)
      OP_LW, OP_SW:         r = (addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: r = addr_lo[0];
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_lsu_lane_align.sv
// Combinational lane logic: extracts/extends load lanes from the memory word
// and merges sub-word store data into it for read-modify-write.
module lsu_lane_align
  import data_mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [2:0]            i_op,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_mem_word,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [DATA_WIDTH-1:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_byte_en;
  logic [31:0] w_store_lanes;

  assign w_byte = i_mem_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_mem_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_load_data = i_mem_word;
    case (i_op)
      OP_LH:   o_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      OP_LB:   o_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      default: o_load_data = i_mem_word;
    endcase
  end

  // Replicate the store lane across the word so each byte enable picks it up.
  always_comb begin
    w_byte_en     = 4'b1111;
    w_store_lanes = i_store_data[31:0];
    case (i_op)
      OP_SB: begin
        w_byte_en     = 4'b0001 << i_addr_lo;
        w_store_lanes = {4{i_store_data[7:0]}};
      end
      OP_SH: begin
        w_byte_en     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_store_lanes = {2{i_store_data[15:0]}};
      end
      default: begin
        w_byte_en     = 4'b1111;
        w_store_lanes = i_store_data[31:0];
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_merged_word[8*gi +: 8] = w_byte_en[gi] ? w_store_lanes[8*gi +: 8]
                                                      : i_mem_word[8*gi +: 8];
    end
    if (DATA_WIDTH > 32) begin : g_upper
      assign o_merged_word[DATA_WIDTH-1:32] = i_mem_word[DATA_WIDTH-1:32];
    end
  endgenerate

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit sequencing single requests onto a word-addressed data
// memory, with read-modify-write for sub-word stores.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  lsu_state_t            r_state, w_state_next;
  logic [2:0]            r_op, w_op_next;
  logic [DATA_WIDTH-1:0] r_addr, w_addr_next;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_next;
  logic [DATA_WIDTH-1:0] r_merged, w_merged_next;
  logic                  r_err, w_err_next;

  logic                  w_ready;
  logic                  w_mem_rd;
  logic                  w_mem_wr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged_word;

  lsu_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .i_op         (r_op),
    .i_addr_lo    (r_addr[1:0]),
    .i_mem_word   (mem_data_i),
    .i_store_data (r_wdata),
    .o_load_data  (w_load_data),
    .o_merged_word(w_merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_LW;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merged <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_op     <= w_op_next;
      r_addr   <= w_addr_next;
      r_wdata  <= w_wdata_next;
      r_rdata  <= w_rdata_next;
      r_merged <= w_merged_next;
      r_err    <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_op_next     = r_op;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_rdata_next  = r_rdata;
    w_merged_next = r_merged;
    w_err_next    = r_err;
    w_ready       = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_mem_wdata   = '0;

    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (req_valid_i) begin
          w_op_next    = req_op_i;
          w_addr_next  = req_addr_i;
          w_wdata_next = req_wdata_i;
          w_rdata_next = '0;
          w_err_next   = is_misaligned(req_op_i, req_addr_i[1:0]);
          if (w_err_next)
            w_state_next = ST_RESP;
          else if (is_load(req_op_i))
            w_state_next = ST_LOAD;
          else if (req_op_i == OP_SW)
            w_state_next = ST_STORE;
          else
            w_state_next = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        w_mem_rd     = 1'b1;
        w_rdata_next = w_load_data;
        w_state_next = ST_RESP;
      end
      ST_STORE: begin
        w_mem_wr     = 1'b1;
        w_mem_wdata  = r_wdata;
        w_state_next = ST_RESP;
      end
      ST_RMW_RD: begin
        w_mem_rd      = 1'b1;
        w_merged_next = w_merged_word;
        w_state_next  = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        w_mem_wr     = 1'b1;
        w_mem_wdata  = r_merged;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready_o      = w_ready;
  assign resp_valid_o     = (r_state == ST_RESP);
  assign resp_rdata_o     = (r_state == ST_RESP) ? r_rdata : '0;
  assign resp_err_o       = (r_state == ST_RESP) ? r_err : 1'b0;
  assign mem_address_o    = (r_state != ST_IDLE) ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_read_o       = w_mem_rd;
  assign mem_write_data_o = w_mem_wdata;
  // A reset edge must never double as a write edge.
  assign mem_write_o      = w_mem_wr & ~reset;

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit that sits between the MIPS datapath and the word-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake, drives the data memory's word interface (address, write data, write and read strobes), and returns a one-cycle response. Sub-word loads are extracted and extended from the addressed word. Sub-word stores use read-modify-write sequences. Misaligned accesses are flagged without touching memory.

## Interface
- DATA_WIDTH, 32, word width; also the width of every address and data port.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept; high only in IDLE.
- req_op_i  in  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr_i  in  DATA_WIDTH  byte address, including the 0x1001_0000 segment base.
- req_wdata_i  in  DATA_WIDTH  store data; the low byte or half is used for SB/SH.
- resp_valid_o  out  1  one-cycle response strobe.
- resp_rdata_o  out  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err_o  out  1  misaligned access; valid with resp_valid_o.
- mem_address_o  out  DATA_WIDTH  word-aligned address: {addr[31:2],2'b00}.
- mem_write_data_o  out  DATA_WIDTH  word to write.
- mem_write_o  out  1  write strobe; memory writes on the rising edge while this is high.
- mem_read_o  out  1  read enable; mem_data_i is combinationally valid while this is high.
- mem_data_i  in  DATA_WIDTH  read word from memory. It is forced to 0 when mem_read_o is low.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch op, addr and wdata. Next state:
  - RESP with err=1 if misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - Otherwise LOAD for loads, STORE for SW, RMW_RD for SH/SB.
- LOAD: mem_read_o=1. Select the lane from mem_data_i, extend it, and register the result. Next state is RESP.
  - Little-endian lanes: byte k = bits [8k+7:8k] with k=addr[1:0]; half h = bits [16h+15:16h] with h=addr[1].
  - LH/LB sign-extend; LHU/LBU zero-extend.
- STORE: mem_write_o=1, mem_write_data_o=wdata. Next state is RESP.
- RMW_RD: mem_read_o=1. Merge the store lane into mem_data_i, register the merged word, then go to RMW_WR.
- RMW_WR: mem_write_o=1, mem_write_data_o=merged word. Next state is RESP.
- RESP: resp_valid_o=1. Next state is IDLE.
- Outside the states above, mem_write_o=0, mem_read_o=0 and mem_write_data_o=0.
- mem_address_o holds the latched aligned address from accept until IDLE. In IDLE it is 0.
- mem_write_o is gated by !reset, so no write happens on a reset edge.

## Timing
- Reset: state goes to IDLE and all registers clear.
  - Outputs after reset: req_ready_o=1; resp_valid_o=0, resp_rdata_o=0, resp_err_o=0; all mem_* outputs 0.
- Reset during any state aborts the operation: no response, and no write during the reset cycle.
- Latency is counted from the accept edge (cycle 0):
  - Load or SW: resp_valid_o in cycle 2.
  - SH/SB: resp_valid_o in cycle 3.
  - Misaligned: resp_valid_o in cycle 1, with zero memory strobes.
- One request is in flight at a time. req_ready_o is low from the cycle after accept through RESP, and the next accept is possible in the cycle after RESP.
- req_valid_i while not ready is ignored. The requester holds the request until it is accepted.
- The response is not back-pressured.

## Structure
- Package data_mem_lsu_pkg holds:
  - the op encoding as localparams;
  - the state enum;
  - DATA_WIDTH default;
  - DATA_SEG_BASE = 32'h1001_0000, used by benches only.
- Sub-module lsu_lane_align (combinational) performs load extraction/extension and store lane merge, driven by op and addr[1:0]. All sequencing stays in the top module.

## Test plan
- LW 0x1001_0004 with memory word 0xDEADBEEF:
  - cycle 1: mem_read_o=1, mem_address_o=0x1001_0004;
  - cycle 2: resp_rdata_o=0xDEADBEEF, err=0.
- LB 0x1001_0003 → 0xFFFFFFDE; LBU 0x1001_0003 → 0x000000DE; LH 0x1001_0002 → 0xFFFFDEAD; LHU → 0x0000DEAD.
- SB 0x1001_0001 with wdata 0x12345677 over 0xDEADBEEF:
  - RMW_RD read, then write 0xDEAD77EF in cycle 2;
  - resp in cycle 3;
  - a later LW returns 0xDEAD77EF.
- SH 0x1001_0003 → resp in cycle 1 with err=1, rdata=0; mem_write_o and mem_read_o never high; memory unchanged.
- SW 0x1001_0008 with data 0xCAFEF00D, reset asserted in the STORE cycle → no write (word stays 0), no resp_valid_o; req_ready_o=1 the next cycle.
- Back-to-back requests held valid: SW accepted at cycle 0, LW accepted at cycle 3; the LW returns the stored value at cycle 5.
